// File: rtl/poly_song_reader.sv
// poly_song_reader
//   Walks a song ROM ({song_q, addr}) and decodes note and rest words. Each note
//   is handed to the lowest-index free note player. Rests are timed against
//   beat_tick. The reader stalls while every voice is busy, and can either loop
//   the song or stop at its end.
//
// Ports
//   clk, reset_n       clock, asynchronous active-low reset
//   play, loop, song   run/pause level, loop enable, song select
//   beat_tick          rest timebase pulse
//   note_done          per-voice "note player finished" pulses
//   rom_addr/rom_data  song ROM port (data valid one cycle after address)
//   new_note           one-hot per-voice load strobe, with note/duration
//   voice_busy         per-voice busy flags
//   song_done          one-cycle end-of-song pulse
//   playing            high in every state except PAUSED and DONE

// Per-voice busy flag. A set in the same cycle as a clear wins, so a freshly
// loaded voice never looks idle.
module poly_song_voice_busy (
    input  logic clk,
    input  logic reset_n,
    input  logic set,
    input  logic clr,
    output logic busy
);
    logic busy_q, busy_d;

    always_comb busy_d = set | (busy_q & ~clr);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) busy_q <= 1'b0;
        else          busy_q <= busy_d;
    end

    assign busy = busy_q;
endmodule

module poly_song_reader #(
    parameter  int NUM_VOICES      = 3,
    parameter  int SONG_SEL_WIDTH  = 2,
    parameter  int SONG_ADDR_WIDTH = 7,
    parameter  int NOTE_WIDTH      = 6,
    parameter  int DUR_WIDTH       = 6,
    localparam int WORD_W          = 1 + NOTE_WIDTH + DUR_WIDTH + 3
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic                                    play,
    input  logic                                    loop,
    input  logic [SONG_SEL_WIDTH-1:0]               song,
    input  logic                                    beat_tick,
    input  logic [NUM_VOICES-1:0]                   note_done,
    output logic [SONG_SEL_WIDTH+SONG_ADDR_WIDTH-1:0] rom_addr,
    input  logic [WORD_W-1:0]                       rom_data,
    output logic [NUM_VOICES-1:0]                   new_note,
    output logic [NOTE_WIDTH-1:0]                   note,
    output logic [DUR_WIDTH-1:0]                    duration,
    output logic [NUM_VOICES-1:0]                   voice_busy,
    output logic                                    song_done,
    output logic                                    playing
);
    localparam logic [2:0] S_PAUSED  = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_DECODE  = 3'd2;
    localparam logic [2:0] S_STALL   = 3'd3;
    localparam logic [2:0] S_ISSUE   = 3'd4;
    localparam logic [2:0] S_WAIT    = 3'd5;
    localparam logic [2:0] S_ADVANCE = 3'd6;
    localparam logic [2:0] S_DONE    = 3'd7;

    localparam int FLD_W = NOTE_WIDTH + DUR_WIDTH;

    logic [2:0]                 state_q, state_d;
    logic [SONG_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [SONG_SEL_WIDTH-1:0]  song_q, song_d;
    logic [FLD_W-1:0]           fields_q, fields_d;   // {note, duration} of the latched word
    logic [DUR_WIDTH-1:0]       wait_q, wait_d;
    logic                       song_done_q, song_done_d;

    logic                       rd_rest, rd_end, song_end;
    logic                       any_free;
    logic [NUM_VOICES-1:0]      grant;

    assign rd_rest  = rom_data[WORD_W-1];
    assign rd_end   = (rom_data[2:0] == 3'b111);
    assign any_free = ~(&voice_busy);

    // Lowest-index free voice; the low index is scanned last so it wins.
    always_comb begin
        grant = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (!voice_busy[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        song_d      = song_q;
        fields_d    = fields_q;
        wait_d      = wait_q;
        song_done_d = 1'b0;
        song_end    = 1'b0;
        case (state_q)
            S_PAUSED: begin
                if (play) begin
                    state_d = S_FETCH;
                end else if (song != song_q) begin
                    song_d = song;
                    addr_d = '0;
                end
            end
            S_FETCH: state_d = play ? S_DECODE : S_PAUSED;
            S_DECODE: begin
                fields_d = rom_data[WORD_W-2:3];
                if (!play) begin
                    state_d = S_PAUSED;
                end else if (rd_end) begin
                    song_end = 1'b1;
                end else if (rd_rest) begin
                    state_d = S_WAIT;
                    wait_d  = rom_data[DUR_WIDTH+2:3];
                end else begin
                    state_d = any_free ? S_ISSUE : S_STALL;
                end
            end
            // A stalled note must go out even if play drops meanwhile.
            S_STALL: if (any_free) state_d = S_ISSUE;
            S_ISSUE: state_d = S_ADVANCE;
            S_WAIT: begin
                if (!play) begin
                    state_d = S_PAUSED;
                end else if (wait_q == '0) begin
                    state_d = S_ADVANCE;
                end else if (beat_tick) begin
                    wait_d = wait_q - DUR_WIDTH'(1);
                end
            end
            S_ADVANCE: begin
                addr_d = addr_q + SONG_ADDR_WIDTH'(1);
                if (&addr_q) song_end = 1'b1;
                else         state_d  = play ? S_FETCH : S_PAUSED;
            end
            S_DONE: if (!play) state_d = S_PAUSED;
            default: state_d = S_PAUSED;
        endcase

        if (song_end) begin
            song_done_d = 1'b1;
            addr_d      = '0;
            state_d     = (loop && play) ? S_FETCH : S_DONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_PAUSED;
            addr_q      <= '0;
            song_q      <= '0;
            fields_q    <= '0;
            wait_q      <= '0;
            song_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            song_q      <= song_d;
            fields_q    <= fields_d;
            wait_q      <= wait_d;
            song_done_q <= song_done_d;
        end
    end

    // Outputs decode from registered state only, so reset clears them at once.
    assign new_note  = (state_q == S_ISSUE) ? grant : '0;
    assign note      = (state_q == S_ISSUE) ? fields_q[FLD_W-1:DUR_WIDTH] : '0;
    assign duration  = (state_q == S_ISSUE) ? fields_q[DUR_WIDTH-1:0] : '0;
    assign rom_addr  = {song_q, addr_q};
    assign song_done = song_done_q;
    assign playing   = (state_q != S_PAUSED) && (state_q != S_DONE);

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
        poly_song_voice_busy u_busy (
            .clk     (clk),
            .reset_n (reset_n),
            .set     (new_note[g]),
            .clr     (note_done[g]),
            .busy    (voice_busy[g])
        );
    end
endmodule

// File: tb/tb_poly_song_reader.sv
module tb_poly_song_reader;
    localparam int NV = 3, SW = 2, AW = 7, NW = 6, DW = 6, WW = 16;

    logic              clk = 1'b0;
    logic              reset_n, play, loop, beat_tick;
    logic [SW-1:0]     song;
    logic [NV-1:0]     note_done, new_note, voice_busy;
    logic [SW+AW-1:0]  rom_addr;
    logic [WW-1:0]     rom_data;
    logic [NW-1:0]     note;
    logic [DW-1:0]     duration;
    logic              song_done, playing;

    logic [WW-1:0]     rom [0:(1<<(SW+AW))-1];
    int checks = 0, failures = 0, cyc = 0, tick_mode = 0;

    poly_song_reader #(.NUM_VOICES(NV), .SONG_SEL_WIDTH(SW), .SONG_ADDR_WIDTH(AW),
                       .NOTE_WIDTH(NW), .DUR_WIDTH(DW)) dut (
        .clk(clk), .reset_n(reset_n), .play(play), .loop(loop), .song(song),
        .beat_tick(beat_tick), .note_done(note_done), .rom_addr(rom_addr),
        .rom_data(rom_data), .new_note(new_note), .note(note), .duration(duration),
        .voice_busy(voice_busy), .song_done(song_done), .playing(playing));

    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= rom[rom_addr];

    function automatic logic [WW-1:0] mk(input int t, input int n, input int d, input int m);
        return {t[0], NW'(n), DW'(d), 3'(m)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1; cyc++;
        case (tick_mode)
            1:       beat_tick = (cyc % 5 == 0);
            2:       beat_tick = ($urandom_range(0, 2) == 0);
            default: beat_tick = 1'b0;
        endcase
    endtask

    // Called in the FETCH cycle of a rest word. The rest spans FETCH, DECODE,
    // then WAIT until `dur` ticks land (ticks count from the first WAIT cycle,
    // k=2), one more WAIT cycle at zero, ADVANCE; the next word's address shows
    // three cycles after the last counted tick (k=4 for a zero rest).
    task automatic rest_check(input int dur, input logic [SW+AW-1:0] nxt, input string tag);
        int cnt, kt, got;
        cnt = 0; kt = 1; got = -1;
        for (int k = 0; k < 300 && got < 0; k++) begin
            if (rom_addr === nxt) got = k;
            else begin
                if (k >= 2 && beat_tick && cnt < dur) begin
                    cnt++;
                    if (cnt == dur) kt = k;
                end
                step();
            end
        end
        chk({tag, "_len"}, got, kt + 3);
    endtask

    initial begin
        int exp_n[$], exp_d[$];
        logic [NV-1:0] busy_m, nn_prev, nd_prev, exp_oh;
        int ptr, done_cnt, got, pulses;
        logic [SW+AW-1:0] wrap_addr;

        for (int i = 0; i < (1<<(SW+AW)); i++) rom[i] = mk(1, 0, 0, 0);
        rom[128] = mk(0, 12, 8, 0);  rom[129] = mk(0, 20, 3, 0);
        rom[130] = mk(0, 33, 1, 0);  rom[131] = mk(0, 45, 63, 0);
        rom[132] = mk(0, 0, 0, 7);
        rom[256] = mk(0, 5, 1, 0);   rom[257] = mk(1, 9, 9, 7);
        rom[384] = mk(1, 0, 3, 0);   rom[385] = mk(1, 0, 0, 0);
        rom[386] = mk(0, 33, 7, 0);  rom[387] = mk(1, 0, 5, 0);
        rom[388] = mk(0, 0, 0, 7);

        reset_n = 0; play = 0; loop = 0; song = 1; beat_tick = 0; note_done = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_new_note", new_note, 0);   chk("rst_note", note, 0);
        chk("rst_duration", duration, 0);   chk("rst_busy", voice_busy, 0);
        chk("rst_song_done", song_done, 0); chk("rst_playing", playing, 0);
        chk("rst_rom_addr", rom_addr, 0);
        #3 reset_n = 1;

        // first note: song select picked up while paused, note out 3 cycles after play
        step(); chk("sel_addr", rom_addr, 9'h080); chk("sel_playing", playing, 0);
        play = 1;
        step(); chk("fetch_playing", playing, 1); chk("fetch_addr", rom_addr, 9'h080);
        chk("fetch_nn", new_note, 0);
        step(); chk("decode_nn", new_note, 0);
        step(); chk("n0_nn", new_note, 3'b001); chk("n0_note", note, 12); chk("n0_dur", duration, 8);
        step(); chk("n0_busy", voice_busy, 3'b001); chk("adv_note", note, 0);
        repeat (3) step();
        chk("n1_nn", new_note, 3'b010); chk("n1_note", note, 20); chk("n1_dur", duration, 3);
        repeat (4) step();
        chk("n2_nn", new_note, 3'b100); chk("n2_note", note, 33); chk("n2_dur", duration, 1);
        repeat (4) step();
        chk("stall_nn", new_note, 0); chk("stall_busy", voice_busy, 3'b111);
        chk("stall_playing", playing, 1);
        step(); chk("stall_nn2", new_note, 0);
        note_done = 3'b010;
        step(); note_done = 0; chk("done1_busy", voice_busy, 3'b101); chk("stall_nn3", new_note, 0);
        step(); chk("n3_nn", new_note, 3'b010); chk("n3_note", note, 45); chk("n3_dur", duration, 63);
        step(); chk("n3_busy", voice_busy, 3'b111);
        step(); chk("w4_addr", rom_addr, 9'h084);
        step();
        step(); chk("end_done", song_done, 1); chk("end_playing", playing, 0);
        chk("end_addr", rom_addr, 9'h080);
        step(); chk("end_pulse", song_done, 0); chk("done_hold", playing, 0);
        play = 0; note_done = 3'b111;
        step(); note_done = 0; chk("paused_playing", playing, 0); chk("clear_busy", voice_busy, 0);
        play = 1;
        step(); chk("restart_addr", rom_addr, 9'h080); chk("restart_playing", playing, 1);

        // pause in FETCH keeps addr; then looping song 2 (end marker with rest type)
        play = 0;
        step(); chk("fpause_playing", playing, 0); chk("fpause_addr", rom_addr, 9'h080);
        song = 2; loop = 1;
        step(); chk("sel2_addr", rom_addr, 9'h100);
        play = 1;
        step(); chk("s2_fetch", rom_addr, 9'h100);
        repeat (2) step();
        chk("s2_nn", new_note, 3'b001); chk("s2_note", note, 5); chk("s2_dur", duration, 1);
        repeat (2) step(); chk("s2_w1", rom_addr, 9'h101);
        step();
        step(); chk("loop_done", song_done, 1); chk("loop_playing", playing, 1);
        chk("loop_addr", rom_addr, 9'h100);
        loop = 0;
        step(); chk("loop_pulse", song_done, 0);
        step(); chk("loop_nn", new_note, 3'b010); chk("loop_note", note, 5);
        repeat (4) step();
        chk("s2_end_done", song_done, 1); chk("s2_end_playing", playing, 0);
        play = 0; note_done = 3'b111;
        step(); note_done = 0;

        // rests against a tick every 5 cycles, and pause inside a rest
        song = 3;
        step(); chk("sel3_addr", rom_addr, 9'h180);
        tick_mode = 1; play = 1;
        step();
        rest_check(3, 9'h181, "rest3");
        rest_check(0, 9'h182, "rest0");
        repeat (2) step();
        chk("s3_nn", new_note, 3'b001); chk("s3_note", note, 33); chk("s3_dur", duration, 7);
        repeat (2) step(); chk("s3_w3", rom_addr, 9'h183);
        repeat (4) step();
        play = 0;
        step(); chk("wpause_playing", playing, 0); chk("wpause_addr", rom_addr, 9'h183);
        step(); chk("wpause_hold", rom_addr, 9'h183);
        play = 1;
        step(); chk("resume_playing", playing, 1); chk("resume_addr", rom_addr, 9'h183);
        rest_check(5, 9'h184, "rest5_resume");
        repeat (2) step();
        chk("s3_done", song_done, 1); chk("s3_playing", playing, 0);
        play = 0; tick_mode = 0;
        step();

        // 128 zero rests, no marker: song end on the 127 -> 0 wrap
        song = 0;
        step(); chk("sel0_addr", rom_addr, 0);
        play = 1; got = -1; pulses = 0; wrap_addr = '1;
        for (int k = 1; k <= 520; k++) begin
            step();
            if (song_done) begin
                pulses++;
                if (got < 0) begin got = k; wrap_addr = rom_addr; end
            end
        end
        chk("wrap_cycle", got, 513); chk("wrap_addr", wrap_addr, 0); chk("wrap_pulses", pulses, 1);
        play = 0;
        step();

        // reset asserted during ISSUE
        reset_n = 0; step(); reset_n = 1; song = 1;
        step(); play = 1;
        repeat (3) step();
        chk("pre_rst_nn", new_note, 3'b001);
        #2 reset_n = 0;
        #1;
        chk("arst_nn", new_note, 0); chk("arst_note", note, 0); chk("arst_dur", duration, 0);
        chk("arst_playing", playing, 0); chk("arst_busy", voice_busy, 0);
        chk("arst_addr", rom_addr, 0); chk("arst_done", song_done, 0);

        // random song, random play/tick/note_done, looping
        play = 0;
        step(); reset_n = 1;
        for (int w = 0; w < 7; w++) begin
            if (w == 0 || $urandom_range(0, 9) < 6) begin
                int n, d;
                n = $urandom_range(0, 63); d = $urandom_range(0, 63);
                rom[256 + w] = mk(0, n, d, $urandom_range(0, 6));
                exp_n.push_back(n); exp_d.push_back(d);
            end else begin
                rom[256 + w] = mk(1, $urandom_range(0, 63), $urandom_range(0, 3), $urandom_range(0, 6));
            end
        end
        rom[263] = mk($urandom_range(0, 1), $urandom_range(0, 63), $urandom_range(0, 63), 7);
        song = 2; loop = 1;
        step();
        busy_m = '0; ptr = 0; done_cnt = 0; tick_mode = 2;
        for (int c = 0; c < 3000; c++) begin
            play = ($urandom_range(0, 15) != 0);
            note_done = '0;
            for (int i = 0; i < NV; i++) if ($urandom_range(0, 3) == 0) note_done[i] = 1'b1;
            nn_prev = new_note; nd_prev = note_done;
            step();
            busy_m = nn_prev | (busy_m & ~nd_prev);
            chk("rnd_busy", voice_busy, busy_m);
            if (new_note != 0) begin
                exp_oh = ~busy_m & (busy_m + 1'b1);
                chk("rnd_pick", new_note, exp_oh);
                if (ptr < exp_n.size()) begin
                    chk("rnd_note", note, exp_n[ptr]);
                    chk("rnd_dur", duration, exp_d[ptr]);
                end else chk("rnd_extra", ptr, exp_n.size());
                ptr++;
            end
            if (song_done) begin
                chk("rnd_song_len", ptr, exp_n.size());
                ptr = 0; done_cnt++;
            end
        end
        chk("rnd_progress", done_cnt > 3, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/poly_song_reader.md
Name: poly_song_reader

Overview:
Parametrised, N-voice successor to the three-voice song reader. It walks a song ROM selected by `song` and decodes note and rest words. Notes go to the lowest-index free note player; rests are timed internally against `beat_tick`. The block stalls when all voices are busy, supports loop or one-shot playback, and pulses `song_done` at end of song. It sits between the external song ROM and an array of NUM_VOICES note players.

Parameters:
NUM_VOICES, 3, number of note players driven (>=1)
SONG_SEL_WIDTH, 2, width of song select; 2^SONG_SEL_WIDTH songs
SONG_ADDR_WIDTH, 7, word address within one song; 2^SONG_ADDR_WIDTH words per song
NOTE_WIDTH, 6, note field width
DUR_WIDTH, 6, duration / rest-length field width
WORD_W, 1+NOTE_WIDTH+DUR_WIDTH+3, ROM word width (derived, not overridden)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
play  in  1  level; 1 = run, 0 = pause
loop  in  1  1 = restart at word 0 after end of song, 0 = stop
song  in  SONG_SEL_WIDTH  song select
beat_tick  in  1  one-cycle timebase pulse for rests
note_done  in  NUM_VOICES  per-voice pulse: note player finished
rom_addr  out  SONG_SEL_WIDTH+SONG_ADDR_WIDTH  {song_q, word address}
rom_data  in  WORD_W  ROM word; valid 1 cycle after rom_addr
new_note  out  NUM_VOICES  one-hot, one-cycle load strobe per voice
note  out  NOTE_WIDTH  note field; valid while any new_note bit is high
duration  out  DUR_WIDTH  duration field; valid while any new_note bit is high
voice_busy  out  NUM_VOICES  per-voice busy flags
song_done  out  1  one-cycle pulse at end of song
playing  out  1  high in every state except PAUSED and DONE

Behaviour:
- ROM word layout: [WORD_W-1] type (1 = rest); next NOTE_WIDTH bits = note; next DUR_WIDTH bits = duration; [2:0] = meta. meta==3'b111 is the end-of-song marker, whatever the type.
- Reset (async, reset_n=0) state:
  - state = PAUSED; addr = 0; song_q = 0; wait counter = 0; voice_busy = 0.
  - new_note = 0, note = 0, duration = 0, song_done = 0, playing = 0.
- States: PAUSED, FETCH, DECODE, STALL, ISSUE, WAIT, ADVANCE, DONE.
- PAUSED:
  - If play=0 and song != song_q, then song_q <= song and addr <= 0.
  - play=1 -> FETCH.
- FETCH: rom_addr is driven from registered addr. -> DECODE.
- DECODE: latch rom_data into the word register, then branch:
  - end marker -> song end (see below);
  - rest -> WAIT, loading counter = duration;
  - note with any voice free -> ISSUE;
  - note with all voices busy -> STALL.
- STALL: -> ISSUE on the first cycle with any voice_busy bit = 0. Holds regardless of play.
- ISSUE:
  - new_note[i] = 1 for i = lowest-index voice with voice_busy[i]=0; note/duration = latched word fields. In all other states new_note = 0 and note/duration = 0.
  - -> ADVANCE unconditionally, so a note is never issued twice.
- WAIT:
  - Counter decrements on each beat_tick.
  - -> ADVANCE when counter==0; a rest of 0 advances on the next cycle.
- ADVANCE:
  - addr <= addr+1.
  - If addr was all-ones (wrap), this is song end. Otherwise -> FETCH if play, else PAUSED.
- Song end (end marker in DECODE, or wrap in ADVANCE):
  - song_done pulses 1 cycle; addr <= 0.
  - loop=1 and play=1 -> FETCH.
  - Otherwise -> DONE.
- DONE: holds until play=0, then -> PAUSED.
- Pause:
  - play=0 in FETCH, DECODE or WAIT -> PAUSED next cycle; addr is preserved.
  - On resume the current word is re-fetched, so a paused rest restarts at its full length.
- Latency:
  - play sampled high in PAUSED at cycle 0 -> new_note at cycle 3.
  - An unstalled note word costs 4 cycles.
  - A rest costs 3 cycles + the time to count duration beat_ticks.
- Busy flags:
  - voice_busy[i] set by new_note[i], cleared by note_done[i].
  - new_note and note_done on the same voice in the same cycle -> busy stays 1.
  - note_done on an idle voice is ignored.
- Width rules: addr is SONG_ADDR_WIDTH bits and wraps modulo 2^SONG_ADDR_WIDTH; the wrap is detected from the pre-increment all-ones value.
- Reset asserted mid-operation: everything returns to reset values immediately, including any in-progress new_note.

Test Plan:
- Reset, song=1, play=1, word0 = note 6'd12, dur 6'd8 -> rom_addr=0x80 in FETCH; new_note=3'b001, note=12, duration=8 exactly 3 cycles after play; voice_busy=3'b001.
- Four consecutive note words, no note_done -> voices 0,1,2 issued, then STALL. A note_done[1] pulse -> next note goes to voice 1 on the following ISSUE.
- Rest word, duration 3, with beat_tick every 5 cycles -> stays in WAIT until the third tick, then ADVANCE. Rest with duration 0 -> no waiting.
- End marker at word 4, loop=0 -> one-cycle song_done, playing=0 (DONE). play 1->0->1 -> restarts at rom_addr word 0. Same with loop=1 -> FETCH of word 0 directly, no drop in playing.
- 128-word song with no marker -> song_done at wrap 127->0. Pause during WAIT, then resume -> same word re-fetched and the rest restarts at full length.
- reset_n pulsed low during ISSUE -> new_note drops asynchronously; all outputs read zero.
